// File: rtl/memory_str_reader.sv
// Text-bitmap ROM reader: fetches one glyph row per raster line and serialises
// it MSB-first into a pixel stream, with integer horizontal/vertical upscaling.
module memory_str_reader #(
  parameter int width_p = 32,
  parameter int depth_p = 8,
  parameter int rows_p  = 64,
  parameter int scale_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               frame_start_i,
  input  logic               line_start_i,
  input  logic               px_en_i,
  input  logic [depth_p-1:0] base_addr_i,
  output logic [depth_p-1:0] addr_o,
  input  logic [width_p-1:0] data_i,
  output logic               pixel_o,
  output logic               pixel_v_o,
  output logic               busy_o,
  output logic               done_o
);

  // state | meaning
  // IDLE  | waiting for a line start (or string complete)
  // FETCH | addr_o presented, ROM word captured at the end of this cycle
  // SHIFT | emitting pixels of the captured row on each strobe
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  localparam int RW = $clog2(rows_p + 1);
  localparam int BW = $clog2(width_p + 1);
  localparam logic [2:0]    REP_LAST = 3'(scale_p - 1);
  localparam logic [RW-1:0] ROWS_END = RW'(rows_p);
  localparam logic [BW-1:0] BIT_LAST = BW'(width_p - 1);

  logic [1:0]         state_q, state_d;
  logic [depth_p-1:0] base_q, base_d;
  logic [depth_p-1:0] addr_q, addr_d;
  logic [RW-1:0]      row_q, row_d;
  logic [2:0]         vrep_q, vrep_d;
  logic [2:0]         hrep_q, hrep_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [width_p-1:0] shreg_q, shreg_d;
  logic               pix_q, pix_d;
  logic               pv_q, pv_d;
  logic               done_q, done_d;

  logic [RW-1:0] row_adv;
  logic [2:0]    vrep_adv;
  logic          done_adv;

  function automatic logic [depth_p-1:0] addr_of(input logic [depth_p-1:0] b,
                                                 input logic [RW-1:0] r);
    logic [RW+depth_p-1:0] s;
    s = {{RW{1'b0}}, b} + {{depth_p{1'b0}}, r};
    return s[depth_p-1:0];
  endfunction

  // Counter values after the current line is counted as complete
  always_comb begin
    vrep_adv = vrep_q + 3'd1;
    row_adv  = row_q;
    if (vrep_q == REP_LAST) begin
      vrep_adv = 3'd0;
      row_adv  = row_q + RW'(1);
    end
    done_adv = (row_adv == ROWS_END);
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    row_d   = row_q;
    vrep_d  = vrep_q;
    hrep_d  = hrep_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pix_d   = pix_q;
    pv_d    = 1'b0;
    done_d  = done_q;

    if (frame_start_i) begin
      row_d  = '0;
      vrep_d = '0;
      hrep_d = '0;
      bit_d  = '0;
      done_d = 1'b0;
      base_d = base_addr_i;
      if (line_start_i) begin
        state_d = FETCH;
        addr_d  = base_addr_i;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (line_start_i && !done_q) begin
            state_d = FETCH;
            addr_d  = addr_of(base_q, row_q);
          end
        end
        FETCH: begin
          shreg_d = data_i;
          bit_d   = '0;
          hrep_d  = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          // A new line start wins over a coincident strobe and ends this line early
          if (line_start_i) begin
            vrep_d = vrep_adv;
            row_d  = row_adv;
            done_d = done_adv;
            if (done_adv) begin
              state_d = IDLE;
            end else begin
              state_d = FETCH;
              addr_d  = addr_of(base_q, row_adv);
            end
          end else if (px_en_i) begin
            pix_d = shreg_q[width_p-1];
            pv_d  = 1'b1;
            if (hrep_q == REP_LAST) begin
              hrep_d  = '0;
              shreg_d = {shreg_q[width_p-2:0], 1'b0};
              bit_d   = bit_q + BW'(1);
              if (bit_q == BIT_LAST) begin
                state_d = IDLE;
                vrep_d  = vrep_adv;
                row_d   = row_adv;
                done_d  = done_adv;
              end
            end else begin
              hrep_d = hrep_q + 3'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      row_q   <= '0;
      vrep_q  <= '0;
      hrep_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      pix_q   <= 1'b0;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      vrep_q  <= vrep_d;
      hrep_q  <= hrep_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      pix_q   <= pix_d;
      pv_q    <= pv_d;
      done_q  <= done_d;
    end
  end

  assign addr_o    = addr_q;
  assign pixel_o   = pix_q;
  assign pixel_v_o = pv_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;

endmodule

// File: tb/tb_memory_str_reader.sv
// Scoreboard bench for memory_str_reader: three instances with different
// row/scale settings, one driven at a time, pixel stream checked by a monitor.
module tb_memory_str_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  fs, ls, px;
  logic [7:0]  base [3];
  logic [7:0]  addr [3];
  logic [31:0] data [3];
  logic [2:0]  pix, pv, busy, done;

  typedef struct {
    logic px;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  int   active = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_f(input logic [7:0] a);
    return {a, 24'h0} ^ 32'h8000_0001;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    memory_str_reader #(
      .width_p(32), .depth_p(8),
      .rows_p (g == 2 ? 4 : 64),
      .scale_p(g == 1 ? 2 : 1)
    ) u_dut (
      .clk_i(clk), .reset_i(rst),
      .frame_start_i(fs[g]), .line_start_i(ls[g]), .px_en_i(px[g]),
      .base_addr_i(base[g]), .addr_o(addr[g]), .data_i(data[g]),
      .pixel_o(pix[g]), .pixel_v_o(pv[g]), .busy_o(busy[g]), .done_o(done[g])
    );
    assign data[g] = rom_f(addr[g]);
  end

  // Monitor: every valid pixel must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (pv[g] === 1'b1) begin
        cmp_cnt++;
        if (g != active || q.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_pixel inst%0d: got pixel_v_o=1 at cycle %0d, required no pixel", g, cyc);
        end else begin
          e = q.pop_front();
          if (pix[g] !== e.px || cyc != e.cyc) begin
            err_cnt++;
            $display("FAIL pixel inst%0d: got %b at cycle %0d, required %b at cycle %0d",
                     g, pix[g], cyc, e.px, e.cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic frame(input int g, input logic [7:0] b);
    base[g] = b;
    fs[g] = 1'b1;
    tick();
    fs[g] = 1'b0;
  endtask

  task automatic line_start(input int g, input logic [7:0] exp_addr, input string name);
    ls[g] = 1'b1;
    tick();
    ls[g] = 1'b0;
    check({name, "_addr"}, addr[g], exp_addr);
    check({name, "_busy"}, busy[g], 1);
  endtask

  task automatic strobes(input int g, input logic [31:0] w, input int sc, input int n);
    for (int i = 0; i < n; i++) begin
      px[g] = 1'b1;
      q.push_back('{w[31 - i / sc], cyc + 1});
      tick();
    end
    px[g] = 1'b0;
  endtask

  task automatic full_line(input int g, input logic [7:0] exp_addr, input logic [31:0] w,
                           input int sc, input string name);
    line_start(g, exp_addr, name);
    tick();
    strobes(g, w, sc, 32 * sc);
    check({name, "_idle_after"}, busy[g], 0);
  endtask

  task automatic drain(input string name);
    tick();
    tick();
    check({name, "_outstanding"}, q.size(), 0);
  endtask

  task automatic dead_strobes(input int g, input int n);
    px[g] = 1'b1;
    repeat (n) tick();
    px[g] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fs = '0; ls = '0; px = '0;
    for (int g = 0; g < 3; g++) base[g] = 8'h00;
    tick();
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_addr%0d", g), addr[g], 0);
      check($sformatf("rst_pix%0d", g), pix[g], 0);
      check($sformatf("rst_pv%0d", g), pv[g], 0);
      check($sformatf("rst_busy%0d", g), busy[g], 0);
      check($sformatf("rst_done%0d", g), done[g], 0);
    end
    rst = 1'b0;
    tick();

    // Basic line, dropped strobes in IDLE and FETCH
    active = 0;
    frame(0, 8'h10);
    full_line(0, 8'h10, 32'h9000_0001, 1, "t1_row0");
    drain("t1a");
    check("t1_done", done[0], 0);
    dead_strobes(0, 3);
    line_start(0, 8'h11, "t1_row1");
    dead_strobes(0, 1);
    strobes(0, 32'h9100_0001, 1, 32);
    check("t1_row1_idle_after", busy[0], 0);
    drain("t1b");

    // Abort after 10 strobes
    frame(0, 8'h20);
    line_start(0, 8'h20, "t4_row0");
    tick();
    strobes(0, 32'hA000_0001, 1, 10);
    line_start(0, 8'h21, "t4_abort");
    tick();
    strobes(0, 32'hA100_0001, 1, 32);
    check("t4_idle_after", busy[0], 0);
    drain("t4");

    // frame_start mid-SHIFT with a coincident strobe
    line_start(0, 8'h22, "t6_row2");
    tick();
    strobes(0, 32'hA200_0001, 1, 5);
    base[0] = 8'h40;
    fs[0] = 1'b1;
    px[0] = 1'b1;
    tick();
    fs[0] = 1'b0;
    px[0] = 1'b0;
    check("t6_fs_busy", busy[0], 0);
    check("t6_fs_pv", pv[0], 0);
    check("t6_fs_done", done[0], 0);
    full_line(0, 8'h40, 32'hC000_0001, 1, "t6_after_fs");
    drain("t6a");

    // reset mid-SHIFT
    line_start(0, 8'h41, "t6_row1");
    tick();
    strobes(0, 32'hC100_0001, 1, 4);
    px[0] = 1'b1;
    tick();
    px[0] = 1'b0;
    check("t6_pv_before_rst", pv[0], 1);
    rst = 1'b1;
    #1;
    check("t6_rst_pv", pv[0], 0);
    check("t6_rst_pix", pix[0], 0);
    check("t6_rst_addr", addr[0], 0);
    check("t6_rst_busy", busy[0], 0);
    check("t6_rst_done", done[0], 0);
    #2;
    rst = 1'b0;
    tick();
    drain("t6b");
    full_line(0, 8'h00, 32'h8000_0001, 1, "t6_post_rst");
    drain("t6c");

    // scale 2: each bit twice, each row on two lines
    active = 1;
    frame(1, 8'h30);
    full_line(1, 8'h30, 32'hB000_0001, 2, "t2_l0");
    full_line(1, 8'h30, 32'hB000_0001, 2, "t2_l1");
    full_line(1, 8'h31, 32'hB100_0001, 2, "t2_l2");
    full_line(1, 8'h31, 32'hB100_0001, 2, "t2_l3");
    drain("t2");

    // rows 4 with address wrap, then completion
    active = 2;
    frame(2, 8'hFE);
    full_line(2, 8'hFE, 32'h7E00_0001, 1, "t5_l0");
    full_line(2, 8'hFF, 32'h7F00_0001, 1, "t5_l1");
    full_line(2, 8'h00, 32'h8000_0001, 1, "t5_l2");
    check("t3_done_before_last", done[2], 0);
    full_line(2, 8'h01, 32'h8100_0001, 1, "t5_l3");
    check("t3_done", done[2], 1);
    ls[2] = 1'b1;
    tick();
    ls[2] = 1'b0;
    check("t3_no_fetch_busy", busy[2], 0);
    check("t3_no_fetch_addr", addr[2], 8'h01);
    dead_strobes(2, 3);
    check("t3_still_done", done[2], 1);
    drain("t3a");

    // line_start during FETCH is ignored
    frame(2, 8'h08);
    line_start(2, 8'h08, "t3_fetch_ls0");
    line_start(2, 8'h08, "t3_fetch_ls1");
    strobes(2, 32'h8800_0001, 1, 32);
    check("t3_fetch_idle_after", busy[2], 0);
    full_line(2, 8'h09, 32'h8900_0001, 1, "t3_next");
    drain("t3b");

    // frame_start and line_start together
    base[2] = 8'h50;
    fs[2] = 1'b1;
    ls[2] = 1'b1;
    tick();
    fs[2] = 1'b0;
    ls[2] = 1'b0;
    check("t6_fsls_addr", addr[2], 8'h50);
    check("t6_fsls_busy", busy[2], 1);
    tick();
    strobes(2, 32'hD000_0001, 1, 32);
    check("t6_fsls_idle_after", busy[2], 0);
    drain("t6d");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
